// File: rtl/dram_req_arbiter.sv
// dram_req_arbiter
//   Round-robin arbiter that shares the DRAM controller user port between
//   NUM_REQ requesters. One command is in flight at a time. The block tracks
//   each command through ack, execution and read-data return, then routes the
//   completion pulse (and read data) back to the requester that owns it.
//
// Ports
//   u_clk, u_rst_n     clock, asynchronous active-low reset
//   req_valid/ready    per-requester handshake (ready is a one-hot accept pulse)
//   req_cmd            per-requester command, 1 = write, 0 = read
//   req_addr/wdata     packed per-requester address / write data
//   rsp_valid          one-hot completion pulse to the owning requester
//   rsp_data, rsp_err  read data / read-timeout flag, qualified by rsp_valid
//   m_en, m_addr,      downstream enable, address, command and write data
//   m_cmd, m_data_i
//   m_data_o,          downstream read data and its valid pulse
//   m_data_valid
//   m_cmd_ack, m_busy  downstream command-sampled ack and busy
//   stat_sel,          grant statistics readout
//   stat_count
//
// Build option
//   DRAM_ARB_STATS_EN  adds saturating 16-bit grant counters per requester;
//                      without it stat_count is tied to zero.
//
// RD_TIMEOUT must be at least 2.

module dram_req_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned U_ADDR_WIDTH = 12,
    parameter int unsigned U_DATA_WIDTH = 2,
    parameter int unsigned RD_TIMEOUT   = 15,
    parameter int unsigned REQ_ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                             u_clk,
    input  logic                             u_rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_cmd,
    input  logic [NUM_REQ*U_ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*U_DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [U_DATA_WIDTH-1:0]          rsp_data,
    output logic                             rsp_err,
    output logic                             m_en,
    output logic [U_ADDR_WIDTH-1:0]          m_addr,
    output logic                             m_cmd,
    output logic [U_DATA_WIDTH-1:0]          m_data_i,
    input  logic [U_DATA_WIDTH-1:0]          m_data_o,
    input  logic                             m_data_valid,
    input  logic                             m_cmd_ack,
    input  logic                             m_busy,
    input  logic [REQ_ID_WIDTH-1:0]          stat_sel,
    output logic [15:0]                      stat_count
);

    localparam int unsigned CntWidth = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StExec,
        StRdWait
    } state_e;

    state_e                    state_q, state_d;
    logic [REQ_ID_WIDTH-1:0]   last_grant_q, last_grant_d;
    logic [REQ_ID_WIDTH-1:0]   id_q, id_d;
    logic [U_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                      cmd_q, cmd_d;
    logic [U_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                      seen_busy_q, seen_busy_d;
    logic [CntWidth-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
    logic [U_DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                      rsp_err_q, rsp_err_d;

    logic                      win_found;
    logic [REQ_ID_WIDTH-1:0]   win_id;
    logic [REQ_ID_WIDTH-1:0]   cand;

    // Round-robin search starting one past the last grant, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = REQ_ID_WIDTH'((32'(last_grant_q) + i) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        addr_d       = addr_q;
        cmd_d        = cmd_q;
        wdata_d      = wdata_q;
        seen_busy_d  = seen_busy_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = '0;
        rsp_data_d   = '0;
        rsp_err_d    = 1'b0;
        req_ready    = '0;
        m_en         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    req_ready[win_id] = 1'b1;
                    last_grant_d      = win_id;
                    id_d              = win_id;
                    addr_d            = req_addr[win_id*U_ADDR_WIDTH +: U_ADDR_WIDTH];
                    cmd_d             = req_cmd[win_id];
                    wdata_d           = req_wdata[win_id*U_DATA_WIDTH +: U_DATA_WIDTH];
                    state_d           = StIssue;
                end
            end
            StIssue: begin
                m_en = 1'b1;
                if (m_cmd_ack) begin
                    seen_busy_d = 1'b0;
                    state_d     = StExec;
                end
            end
            StExec: begin
                // Enable follows busy directly so it drops in the cycle busy falls.
                m_en = m_busy;
                if (m_busy) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
                    if (cmd_q) begin
                        rsp_valid_d[id_q] = 1'b1;
                        state_d           = StIdle;
                    end else begin
                        // The fall cycle counts as cycle 0, so cnt_q equals the
                        // number of cycles elapsed since busy fell.
                        cnt_d   = CntWidth'(1);
                        state_d = StRdWait;
                    end
                end
            end
            StRdWait: begin
                if (m_data_valid) begin
                    rsp_valid_d[id_q] = 1'b1;
                    rsp_data_d        = m_data_o;
                    state_d           = StIdle;
                end else if (cnt_q == CntWidth'(RD_TIMEOUT - 1)) begin
                    // Registered, so the error response lands RD_TIMEOUT cycles after the fall.
                    rsp_valid_d[id_q] = 1'b1;
                    rsp_err_d         = 1'b1;
                    state_d           = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= REQ_ID_WIDTH'(NUM_REQ - 1);
            id_q         <= '0;
            addr_q       <= '0;
            cmd_q        <= 1'b0;
            wdata_q      <= '0;
            seen_busy_q  <= 1'b0;
            cnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            addr_q       <= addr_d;
            cmd_q        <= cmd_d;
            wdata_q      <= wdata_d;
            seen_busy_q  <= seen_busy_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign m_addr    = addr_q;
    assign m_cmd     = cmd_q;
    assign m_data_i  = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

`ifdef DRAM_ARB_STATS_EN
    logic [15:0] grant_cnt_q [NUM_REQ];

    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && (grant_cnt_q[i] != 16'hFFFF)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    assign stat_count = (32'(stat_sel) < NUM_REQ) ? grant_cnt_q[stat_sel] : 16'h0;
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_count      = 16'h0;
`endif

endmodule

// File: doc/dram_req_arbiter.md
Name: dram_req_arbiter

Overview:
- Shares the single user port of the DRAM controller between NUM_REQ requesters using round-robin arbitration.
- Serialises commands, one in flight at a time, and generates the downstream enable, command and address fields.
- Tracks each transaction through acknowledge, execution and read-data return, then routes the completion or read data back to the owning requester.
- Sits between the client blocks and the DRAM controller's user interface.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
U_ADDR_WIDTH, 12, downstream address width <bank,row,col>
U_DATA_WIDTH, 2, data width
RD_TIMEOUT, 15, maximum cycles to wait for m_data_valid after m_busy falls on a read
REQ_ID_WIDTH, $clog2(NUM_REQ), derived; never overridden

Ports:
u_clk  in  1  clock
u_rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester command request
req_ready  out  NUM_REQ  one-hot accept pulse; transfer occurs when req_valid & req_ready
req_cmd  in  NUM_REQ  1=write, 0=read, per requester
req_addr  in  NUM_REQ*U_ADDR_WIDTH  packed addresses; requester i uses slice i
req_wdata  in  NUM_REQ*U_DATA_WIDTH  packed write data
rsp_valid  out  NUM_REQ  one-hot completion pulse (write done or read data)
rsp_data  out  U_DATA_WIDTH  read data, valid with rsp_valid
rsp_err  out  1  read timed out, qualifies rsp_valid
m_en  out  1  downstream enable
m_addr  out  U_ADDR_WIDTH  downstream address
m_cmd  out  1  downstream command
m_data_i  out  U_DATA_WIDTH  downstream write data
m_data_o  in  U_DATA_WIDTH  downstream read data
m_data_valid  in  1  downstream read-data valid pulse
m_cmd_ack  in  1  downstream command-sampled acknowledge
m_busy  in  1  downstream busy
stat_sel  in  REQ_ID_WIDTH  statistics select (see Optional Feature)
stat_count  out  16  grant count of requester stat_sel

Behaviour:
Reset values: all outputs 0; state A_IDLE; round-robin pointer points at requester NUM_REQ-1, so requester 0 wins first.

States:
- A_IDLE: if any req_valid, pick the winner by round-robin search starting at last_grant+1 with wrap-around. Pulse req_ready[winner] for this cycle. Register addr/cmd/wdata/id. Update last_grant. Go to A_ISSUE next cycle.
- A_ISSUE: m_en=1 and fields are driven from the registers. Stay here while m_cmd_ack=0; this covers m_busy=1, e.g. a refresh in progress. On m_cmd_ack=1 go to A_EXEC.
- A_EXEC: m_en = m_busy, combinational, so enable drops in the same cycle busy falls and no spurious re-sample occurs. Wait for m_busy to go 1 and then 0; track with a seen_busy flag.
  - On the fall with a write: pulse rsp_valid[id] next cycle and go to A_IDLE.
  - On the fall with a read: go to A_RDWAIT.
- A_RDWAIT: m_en=0. On m_data_valid: rsp_data<=m_data_o, pulse rsp_valid[id], go to A_IDLE. A cycle counter that reaches RD_TIMEOUT without m_data_valid gives rsp_valid[id]=1, rsp_err=1, rsp_data=0, then A_IDLE.

Handshake and timing rules:
- m_addr, m_cmd and m_data_i are held stable from A_ISSUE until return to A_IDLE.
- Requesters hold valid and fields until req_ready.
- Exactly one req_ready per accepted command.
- Only the granted bit of rsp_valid ever pulses, for one cycle.
- Minimum re-grant gap is 1 cycle after a response; the A_IDLE to A_ISSUE latency is 1 cycle.
- Fairness: with all requesters continuously valid, grants are 0,1,2,3,0,... with no requester skipped.

Boundary conditions:
- m_data_valid outside A_RDWAIT is ignored.
- m_cmd_ack outside A_ISSUE is ignored.
- A req_valid that drops before grant is not granted.
- A single requester valid is granted every time.
- Reset asserted mid-transaction returns to A_IDLE immediately; no rsp_valid is issued for the aborted command.

Optional Feature:
DRAM_ARB_STATS_EN:
- Defined: NUM_REQ 16-bit grant counters, incremented on each req_ready for that requester, saturating at 16'hFFFF and cleared by reset. stat_count = counter[stat_sel], combinational; stat_sel >= NUM_REQ returns 0.
- Undefined: no counters; stat_count tied to 0; stat_sel ignored.

Test Plan:
- Write from requester 2, addr 12'h5A3, wdata 2'b10 -> req_ready[2] pulses; m_addr=12'h5A3, m_cmd=1, m_data_i=2'b10, m_en=1 until m_cmd_ack; one rsp_valid[2] pulse after m_busy falls; m_en=0 in that same cycle.
- Read from requester 0; model returns m_data_valid with m_data_o=2'b01, 2 cycles after m_busy falls -> rsp_valid[0]=1, rsp_data=2'b01, rsp_err=0.
- All 4 requesters valid continuously for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
- Read where the model never asserts m_data_valid -> rsp_valid[id] with rsp_err=1 exactly RD_TIMEOUT(15) cycles after m_busy falls.
- m_busy=1 (refresh) for 20 cycles when a request arrives -> arbiter holds A_ISSUE with m_en=1; command completes after ack; no duplicate ack is handled.
- With DRAM_ARB_STATS_EN: 3 grants to requester 1 -> stat_sel=1 gives stat_count=3; reset asserted during A_EXEC -> all outputs 0 and counters 0 next cycle.
